hidden_layer_sequencer: RTL

//  Sequences one inference pass through HIDDEN_LAYER.
//  - On START: accepts NUM_INPUTS activations from an upstream valid/ready stream.
//  - Forwards each to the layer's serial VALUE_IN/VALID_IN port, but only while the layer reports READY.
//  - Then collects the NUM_OUTPUTS per-neuron results, which may arrive on different cycles.
//  - Presents the full output vector with a one-cycle RESULTS_VALID pulse; flags overflow and timeout.

---
 rtl/hidden_layer_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hidden_layer_sequencer.sv
// rtl/hidden_layer_sequencer.sv - feeds one activation vector into a hidden layer and gathers its outputs
// FSM IDLE -> FEED -> WAIT -> DONE; results are captured first-valid-wins per neuron.
module hidden_layer_sequencer #(
    parameter int NUM_INPUTS     = 16,
    parameter int NUM_OUTPUTS    = 8,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    output logic                         o_busy,
    input  logic [WIDTH-1:0]             i_s_value,
    input  logic                         i_s_valid,
    output logic                         o_s_ready,
    input  logic                         i_layer_ready,
    output logic [WIDTH-1:0]             o_layer_value,
    output logic                         o_layer_valid,
    input  logic [NUM_OUTPUTS*WIDTH-1:0] i_layer_values,
    input  logic [NUM_OUTPUTS-1:0]       i_layer_valids,
    input  logic                         i_layer_overflow,
    output logic [NUM_OUTPUTS*WIDTH-1:0] o_results,
    output logic                         o_results_valid,
    output logic                         o_overflow,
    output logic                         o_timeout
);

    localparam int IW = $clog2(NUM_INPUTS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [IW-1:0]                  r_in_cnt;
    logic [TW-1:0]                  r_tmo_cnt;
    logic [NUM_OUTPUTS-1:0]         r_got;
    logic [NUM_OUTPUTS*WIDTH-1:0]   r_results;
    logic [WIDTH-1:0]               r_layer_value;
    logic                           r_layer_valid;
    logic                           r_overflow;
    logic                           r_timeout;

    logic w_beat;
    logic w_last_beat;
    logic w_all_got;
    logic w_tmo_hit;

    assign o_s_ready   = (r_state == S_FEED) && i_layer_ready && (r_in_cnt < IW'(NUM_INPUTS));
    assign w_beat      = i_s_valid && o_s_ready;
    assign w_last_beat = w_beat && (r_in_cnt == IW'(NUM_INPUTS - 1));
    // Completion counts neurons arriving this very cycle, so it can beat a same-cycle timeout.
    assign w_all_got   = &(r_got | i_layer_valids);
    assign w_tmo_hit   = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_FEED;
            S_FEED: if (w_last_beat) w_next = S_WAIT;
            S_WAIT: begin
                if (w_all_got) w_next = S_DONE;
                else if (w_tmo_hit) w_next = S_IDLE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_in_cnt      <= '0;
            r_tmo_cnt     <= '0;
            r_got         <= '0;
            r_results     <= '0;
            r_layer_value <= '0;
            r_layer_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_layer_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_overflow <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_got      <= '0;
                        r_in_cnt   <= '0;
                        r_tmo_cnt  <= '0;
                    end
                end
                S_FEED: begin
                    if (w_beat) begin
                        r_layer_value <= i_s_value;
                        r_layer_valid <= 1'b1;
                        r_in_cnt      <= r_in_cnt + IW'(1);
                    end
                end
                S_WAIT: begin
                    for (int i = 0; i < NUM_OUTPUTS; i++) begin
                        if (i_layer_valids[i] && !r_got[i]) begin
                            r_results[i*WIDTH +: WIDTH] <= i_layer_values[i*WIDTH +: WIDTH];
                            r_got[i]                    <= 1'b1;
                        end
                    end
                    if (!w_all_got) begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                        if (w_tmo_hit) r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (r_state != S_IDLE && i_layer_overflow) r_overflow <= 1'b1;
        end
    end

    assign o_busy          = (r_state != S_IDLE);
    assign o_layer_value   = r_layer_value;
    assign o_layer_valid   = r_layer_valid;
    assign o_results       = r_results;
    assign o_results_valid = (r_state == S_DONE);
    assign o_overflow      = r_overflow;
    assign o_timeout       = r_timeout;

endmodule
